// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared PID constants, packet/state enums and limits for the USB receive control unit
// Contents:
//   PID_* nibble constants, rx_packet_e (rx_packet encoding), rcu_state_e (RCU FSM states),
//   SYNC_BYTE, MAX_DATA_BYTES and companions, decode_pid() helper.
package usb_pkg;

   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;

   localparam logic [7:0] SYNC_BYTE      = 8'h80;
   localparam logic [6:0] MAX_DATA_BYTES = 7'd66;
   localparam logic [6:0] MIN_DATA_BYTES = 7'd2;
   localparam logic [6:0] TOKEN_BYTES    = 7'd2;

   typedef enum logic [2:0] {
      PKT_NONE  = 3'd0,
      PKT_OUT   = 3'd1,
      PKT_IN    = 3'd2,
      PKT_DATA0 = 3'd3,
      PKT_DATA1 = 3'd4,
      PKT_ACK   = 3'd5,
      PKT_NAK   = 3'd6
   } rx_packet_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_PAYLOAD,
      ST_EOP_WAIT,
      ST_DONE,
      ST_ERR_WAIT
   } rcu_state_e;

   // The PID byte arrives LSB first, so the PID itself is the low nibble and its
   // check field (bitwise complement) is the high nibble. Any mismatch or an
   // unsupported PID decodes to PKT_NONE.
   function automatic rx_packet_e decode_pid(input logic [7:0] pid_byte);
      rx_packet_e pkt;
      pkt = PKT_NONE;
      if (pid_byte[7:4] == ~pid_byte[3:0]) begin
         case (pid_byte[3:0])
            PID_OUT:   pkt = PKT_OUT;
            PID_IN:    pkt = PKT_IN;
            PID_DATA0: pkt = PKT_DATA0;
            PID_DATA1: pkt = PKT_DATA1;
            PID_ACK:   pkt = PKT_ACK;
            PID_NAK:   pkt = PKT_NAK;
            default:   pkt = PKT_NONE;
         endcase
      end
      return pkt;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - parameterised up-counter with synchronous clear and programmable wrap value
// Ports:
//   clk          - clock
//   n_rst        - asynchronous active-low reset
//   clear        - synchronous clear, wins over count_enable
//   count_enable - advance by one
//   rollover_val - last value before the count wraps back to 0
//   count_out    - current count
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out
);

   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;

endmodule

// File: rtl/usb_rx_rcu.sv
// rtl/usb_rx_rcu.sv - USB receive control unit: sync/PID checking, payload length policing, FIFO push
// Ports:
//   clk, n_rst     - clock, asynchronous active-low reset
//   d_edge         - first D+ transition of a packet (pulse)
//   shift_enable   - bit strobe of the receive shift register
//   byte_received  - 8 new bits assembled (pulse); rcv_byte valid in this cycle
//   eop            - SE0 end-of-packet (level)
//   rcv_byte[7:0]  - newest assembled byte
//   rcving         - packet in progress
//   w_enable       - one-cycle RX FIFO push, data on rx_data[7:0]
//   rx_packet[2:0] - decoded PID (rx_packet_e)
//   r_error        - sticky packet error, cleared by the next packet start
//   rx_done        - one-cycle pulse on an error-free packet end
module usb_rx_rcu
   import usb_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_edge,
   input  logic       shift_enable,
   input  logic       byte_received,
   input  logic       eop,
   input  logic [7:0] rcv_byte,
   output logic       rcving,
   output logic       w_enable,
   output logic [7:0] rx_data,
   output logic [2:0] rx_packet,
   output logic       r_error,
   output logic       rx_done
);

   rcu_state_e state_q, state_d;
   rx_packet_e pkt_q, pkt_d;
   logic [6:0] byte_cnt_q, byte_cnt_d;
   logic       r_error_q, r_error_d;
   logic       w_enable_q, w_enable_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic [2:0] bit_cnt;

   flex_counter #(
      .NUM_CNT_BITS(3)
   ) u_bit_cnt (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (byte_received || (state_q == ST_IDLE)),
      .count_enable(shift_enable),
      .rollover_val(3'd7),
      .count_out   (bit_cnt)
   );

   rx_packet_e pid_pkt;
   logic       pid_is_hshake;
   logic       is_data;
   logic [6:0] cnt_inc;
   logic [6:0] cnt_eff;
   logic       byte_over;
   logic       len_ok;
   logic       bits_ok;

   assign pid_pkt       = decode_pid(rcv_byte);
   assign pid_is_hshake = (pid_pkt == PKT_ACK) || (pid_pkt == PKT_NAK);
   assign is_data       = (pkt_q == PKT_DATA0) || (pkt_q == PKT_DATA1);
   assign cnt_inc       = byte_cnt_q + 7'd1;

   // A byte arriving when the count is already at its ceiling is the offending one.
   assign byte_over = is_data ? (byte_cnt_q >= MAX_DATA_BYTES) : (byte_cnt_q >= TOKEN_BYTES);

   // eop is judged after any byte landing in the same cycle; that byte also
   // means the bit counter is effectively back at 0.
   assign cnt_eff = byte_received ? cnt_inc : byte_cnt_q;
   assign len_ok  = is_data ? ((cnt_eff >= MIN_DATA_BYTES) && (cnt_eff <= MAX_DATA_BYTES))
                            : (cnt_eff == TOKEN_BYTES);
   assign bits_ok = byte_received || (bit_cnt == 3'd0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (d_edge) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (byte_received) begin
               state_d = (rcv_byte == SYNC_BYTE) ? ST_PID : ST_ERR_WAIT;
            end else if (eop) begin
               state_d = ST_ERR_WAIT;
            end
         end
         ST_PID: begin
            if (byte_received) begin
               if (pid_pkt == PKT_NONE) state_d = ST_ERR_WAIT;
               else if (pid_is_hshake)  state_d = ST_EOP_WAIT;
               else                     state_d = ST_PAYLOAD;
            end else if (eop) begin
               state_d = ST_ERR_WAIT;
            end
         end
         ST_PAYLOAD: begin
            if (byte_received && byte_over) begin
               state_d = ST_ERR_WAIT;
            end else if (eop) begin
               state_d = (len_ok && bits_ok) ? ST_DONE : ST_ERR_WAIT;
            end
         end
         ST_EOP_WAIT: begin
            if (byte_received) begin
               state_d = ST_ERR_WAIT;
            end else if (eop) begin
               state_d = (bit_cnt == 3'd0) ? ST_DONE : ST_ERR_WAIT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ERR_WAIT: begin
            if (eop) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      pkt_d      = pkt_q;
      r_error_d  = r_error_q;
      w_enable_d = 1'b0;
      rx_data_d  = rx_data_q;

      if ((state_q == ST_IDLE) && d_edge) begin
         byte_cnt_d = '0;
         pkt_d      = PKT_NONE;
         r_error_d  = 1'b0;
      end

      if ((state_q == ST_PID) && byte_received) begin
         pkt_d = pid_pkt;
      end

      if ((state_q == ST_PAYLOAD) && byte_received) begin
         byte_cnt_d = cnt_inc;
         if (is_data && !byte_over) begin
            w_enable_d = 1'b1;
            rx_data_d  = rcv_byte;
         end
      end

      if (state_d == ST_ERR_WAIT) begin
         r_error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         byte_cnt_q <= '0;
         pkt_q      <= PKT_NONE;
         r_error_q  <= 1'b0;
         w_enable_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         pkt_q      <= pkt_d;
         r_error_q  <= r_error_d;
         w_enable_q <= w_enable_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign rcving    = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign rx_done   = (state_q == ST_DONE);
   assign w_enable  = w_enable_q;
   assign rx_data   = rx_data_q;
   assign rx_packet = pkt_q;
   assign r_error   = r_error_q;

endmodule

// File: tb/tb_usb_rx_rcu.sv
// tb/tb_usb_rx_rcu.sv - self-checking bench for usb_rx_rcu with a packet-level reference model
module tb_usb_rx_rcu;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       d_edge = 1'b0;
   logic       shift_enable = 1'b0;
   logic       byte_received = 1'b0;
   logic       eop = 1'b0;
   logic [7:0] rcv_byte = 8'h00;
   logic       rcving;
   logic       w_enable;
   logic [7:0] rx_data;
   logic [2:0] rx_packet;
   logic       r_error;
   logic       rx_done;

   usb_rx_rcu dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .d_edge       (d_edge),
      .shift_enable (shift_enable),
      .byte_received(byte_received),
      .eop          (eop),
      .rcv_byte     (rcv_byte),
      .rcving       (rcving),
      .w_enable     (w_enable),
      .rx_data      (rx_data),
      .rx_packet    (rx_packet),
      .r_error      (r_error),
      .rx_done      (rx_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endfunction

   // Packet-level model: tracks the bytes of the current packet and judges them
   // by position (sync, PID, payload index) rather than by FSM state.
   logic       m_active = 1'b0;
   logic       m_err = 1'b0;
   logic       m_dead = 1'b0;
   int         m_pkt = 0;
   int         m_bits = 0;
   logic [7:0] m_bytes[$];

   logic       exp_wen = 1'b0;
   logic [7:0] exp_data = 8'h00;
   logic       exp_done = 1'b0;
   logic       exp_rcving = 1'b0;
   logic       exp_err = 1'b0;
   int         exp_pkt = 0;
   logic       cmp_en = 1'b0;

   int         wen_cnt = 0;
   int         done_cnt = 0;
   logic [7:0] got_data[$];

   task automatic model_reset();
      m_active = 0; m_err = 0; m_dead = 0; m_pkt = 0; m_bits = 0;
      m_bytes.delete();
      exp_wen = 0; exp_data = 0; exp_done = 0; exp_rcving = 0; exp_err = 0; exp_pkt = 0;
   endtask

   task automatic model_step(input logic de, input logic se, input logic br, input logic ep, input logic [7:0] b);
      int   n;
      int   p;
      logic legal;
      exp_wen  = 0;
      exp_done = 0;
      if (!m_active) begin
         if (m_dead) m_dead = 0;
         else if (de) begin
            m_active = 1; m_err = 0; m_pkt = 0; m_bits = 0;
            m_bytes.delete();
         end
      end else if (m_err) begin
         if (ep) m_active = 0;
      end else begin
         if (br) begin
            m_bits = 0;
            m_bytes.push_back(b);
            n = m_bytes.size();
            if (n == 1) begin
               if (b != 8'h80) m_err = 1;
            end else if (n == 2) begin
               if (b[7:4] != ~b[3:0]) m_err = 1;
               else begin
                  case (b[3:0])
                     4'h1: m_pkt = 1;
                     4'h9: m_pkt = 2;
                     4'h3: m_pkt = 3;
                     4'hB: m_pkt = 4;
                     4'h2: m_pkt = 5;
                     4'hA: m_pkt = 6;
                     default: m_err = 1;
                  endcase
               end
            end else begin
               p = n - 2;
               if (m_pkt >= 5) m_err = 1;
               else if (m_pkt <= 2) begin
                  if (p > 2) m_err = 1;
               end else if (p > 66) m_err = 1;
               else begin
                  exp_wen  = 1;
                  exp_data = b;
               end
            end
         end else if (se) begin
            m_bits = (m_bits + 1) % 8;
         end
         if (ep && !m_err) begin
            n = m_bytes.size();
            if (n < 2) m_err = 1;
            else begin
               p = n - 2;
               if (m_pkt >= 5)      legal = (p == 0);
               else if (m_pkt <= 2) legal = (p == 2);
               else                 legal = (p >= 2) && (p <= 66);
               if (legal && (m_bits == 0)) begin
                  exp_done = 1; m_active = 0; m_dead = 1;
               end else m_err = 1;
            end
         end
      end
      exp_rcving = m_active;
      exp_err    = m_err;
      exp_pkt    = m_pkt;
   endtask

   always @(posedge clk) begin
      #1;
      if (cmp_en) begin
         chk("w_enable", w_enable, exp_wen);
         if (exp_wen) chk("rx_data", rx_data, exp_data);
         chk("rx_done", rx_done, exp_done);
         chk("rcving", rcving, exp_rcving);
         chk("r_error", r_error, exp_err);
         chk("rx_packet", rx_packet, exp_pkt);
         if (w_enable) begin
            wen_cnt++;
            got_data.push_back(rx_data);
         end
         if (rx_done) done_cnt++;
      end
   end

   task automatic cyc(input logic de, input logic se, input logic br, input logic ep, input logic [7:0] b);
      @(negedge clk);
      d_edge = de; shift_enable = se; byte_received = br; eop = ep;
      rcv_byte = br ? b : 8'h00;
      model_step(de, se, br, ep, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_eop);
      for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 8'h00);
      cyc(0, 1, 1, with_eop, b);
   endtask

   task automatic start_pkt();
      wen_cnt = 0; done_cnt = 0;
      got_data.delete();
      cyc(1, 0, 0, 0, 8'h00);
   endtask

   task automatic eop_hold();
      cyc(0, 0, 0, 1, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);
      idle(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("reset_rcving", rcving, 0);
      chk("reset_w_enable", w_enable, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_packet", rx_packet, 0);
      chk("reset_r_error", r_error, 0);
      chk("reset_rx_done", rx_done, 0);
      @(negedge clk);
      model_reset();
      n_rst  = 1'b1;
      cmp_en = 1'b1;
      idle(2);

      // DATA0 with four payload bytes; a stray d_edge mid-payload is ignored
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hC3, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      cyc(1, 0, 0, 0, 8'h00);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      eop_hold();
      chk("data0_wen_count", wen_cnt, 4);
      if (got_data.size() == 4) begin
         chk("data0_byte0", got_data[0], 8'h11);
         chk("data0_byte1", got_data[1], 8'h22);
         chk("data0_byte2", got_data[2], 8'h33);
         chk("data0_byte3", got_data[3], 8'h44);
      end
      chk("data0_done_count", done_cnt, 1);
      chk("data0_rx_packet", rx_packet, 3);
      chk("data0_r_error", r_error, 0);
      chk("data0_rcving", rcving, 0);

      // ACK handshake
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hD2, 0);
      eop_hold();
      chk("ack_rx_packet", rx_packet, 5);
      chk("ack_done_count", done_cnt, 1);
      chk("ack_wen_count", wen_cnt, 0);

      // bad PID complement
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hC4, 0);
      idle(3);
      chk("badpid_r_error", r_error, 1);
      chk("badpid_rx_packet", rx_packet, 0);
      chk("badpid_rcving_held", rcving, 1);
      eop_hold();
      chk("badpid_rcving_after_eop", rcving, 0);
      idle(3);
      chk("badpid_r_error_sticky", r_error, 1);
      start_pkt();
      idle(1);
      chk("badpid_r_error_cleared", r_error, 0);

      // the packet just started carries a bad sync byte
      send_byte(8'h00, 0);
      idle(1);
      chk("badsync_r_error", r_error, 1);
      eop_hold();
      chk("badsync_r_error_after", r_error, 1);
      chk("badsync_done_count", done_cnt, 0);

      // DATA1 with 67 bytes: the 67th overflows
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'h4B, 0);
      for (int i = 0; i < 67; i++) send_byte(8'(i * 3 + 5), 0);
      idle(2);
      chk("long_wen_count", wen_cnt, 66);
      chk("long_r_error", r_error, 1);
      if (got_data.size() == 66) begin
         chk("long_first", got_data[0], 8'h05);
         chk("long_last", got_data[65], 8'hC8);
      end
      eop_hold();
      chk("long_done_count", done_cnt, 0);
      chk("long_rx_packet", rx_packet, 4);

      // OUT token with eop three bits into a byte
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hE1, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h00);
      eop_hold();
      chk("midbyte_r_error", r_error, 1);
      chk("midbyte_done_count", done_cnt, 0);
      chk("midbyte_rx_packet", rx_packet, 1);

      // IN token, exactly two bytes
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'h69, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      eop_hold();
      chk("in_rx_packet", rx_packet, 2);
      chk("in_done_count", done_cnt, 1);
      chk("in_wen_count", wen_cnt, 0);
      chk("in_r_error", r_error, 0);

      // DATA1 with the last byte and eop in the same cycle
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'h4B, 0);
      send_byte(8'hA1, 0);
      send_byte(8'hB2, 1);
      cyc(0, 0, 0, 1, 8'h00);
      idle(2);
      chk("same_wen_count", wen_cnt, 2);
      chk("same_done_count", done_cnt, 1);
      chk("same_rx_packet", rx_packet, 4);
      chk("same_r_error", r_error, 0);

      // reset in the middle of a DATA0 payload
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hC3, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(posedge clk);
      #2;
      chk("prerst_w_enable", w_enable, 1);
      n_rst = 1'b0;
      d_edge = 0; shift_enable = 0; byte_received = 0; eop = 0; rcv_byte = 8'h00;
      cmp_en = 1'b0;
      #1;
      chk("rst_rcving", rcving, 0);
      chk("rst_w_enable", w_enable, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_packet", rx_packet, 0);
      chk("rst_r_error", r_error, 0);
      chk("rst_rx_done", rx_done, 0);
      model_reset();
      @(negedge clk);
      n_rst  = 1'b1;
      cmp_en = 1'b1;
      start_pkt();
      send_byte(8'h80, 0);
      send_byte(8'hD2, 0);
      eop_hold();
      chk("postrst_rx_packet", rx_packet, 5);
      chk("postrst_done_count", done_cnt, 1);
      chk("postrst_r_error", r_error, 0);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
